// File: rtl/dmem_arbiter.sv
// Shares one OBI-style memory data port between the scalar core and the vector unit.
// Vector has priority; a scalar request that keeps losing eventually forces a win.
module dmem_arbiter #(
   parameter int unsigned MEM_W           = 32,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned STARVE_LIMIT    = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   // scalar request / response
   input  logic                                 s_req_i,
   output logic                                 s_gnt_o,
   input  logic [31:0]                          s_addr_i,
   input  logic                                 s_we_i,
   input  logic [3:0]                           s_be_i,
   input  logic [31:0]                          s_wdata_i,
   output logic                                 s_rvalid_o,
   output logic [31:0]                          s_rdata_o,
   output logic                                 s_err_o,
   // vector request / response
   input  logic                                 v_req_i,
   output logic                                 v_gnt_o,
   input  logic [31:0]                          v_addr_i,
   input  logic                                 v_we_i,
   input  logic [MEM_W/8-1:0]                   v_be_i,
   input  logic [MEM_W-1:0]                     v_wdata_i,
   output logic                                 v_rvalid_o,
   output logic [MEM_W-1:0]                     v_rdata_o,
   output logic                                 v_err_o,
   // memory request / response
   output logic                                 m_req_o,
   input  logic                                 m_gnt_i,
   output logic [31:0]                          m_addr_o,
   output logic                                 m_we_o,
   output logic [MEM_W/8-1:0]                   m_be_o,
   output logic [MEM_W-1:0]                     m_wdata_o,
   input  logic                                 m_rvalid_i,
   input  logic [MEM_W-1:0]                     m_rdata_i,
   input  logic                                 m_err_i,
   // status
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] os_cnt_o,
   output logic                                 proto_err_o
);

   localparam int unsigned BeW      = MEM_W / 8;
   localparam int unsigned NumLanes = MEM_W / 32;
   localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
   localparam int unsigned PtrW     = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CntW     = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned EntW     = LaneW + 2;

   logic [7:0]      r_starve;
   logic [CntW-1:0] r_cnt;
   logic [PtrW-1:0] r_wptr;
   logic [PtrW-1:0] r_rptr;
   logic            r_proto;
   // entry layout: {src (1 = vector), we, lane}
   logic [EntW-1:0] r_fifo [MAX_OUTSTANDING];

   logic             w_s_win;
   logic             w_v_win;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [LaneW-1:0] w_s_lane;
   logic [BeW-1:0]   w_s_be;
   logic [EntW-1:0]  w_head;
   logic [EntW-1:0]  w_new_ent;
   logic             w_head_src;
   logic             w_head_we;
   logic [LaneW-1:0] w_head_lane;

   generate
      if (NumLanes > 1) begin : g_lane
         assign w_s_lane = s_addr_i[2 +: LaneW];
      end else begin : g_nolane
         assign w_s_lane = '0;
      end
   endgenerate

   // Winner selection and request path
   assign w_v_win = v_req_i & ~((r_starve == 8'(STARVE_LIMIT)) & s_req_i);
   assign w_s_win = s_req_i & ~w_v_win;
   assign w_full  = (r_cnt == CntW'(MAX_OUTSTANDING));
   assign w_empty = (r_cnt == '0);

   assign m_req_o = (s_req_i | v_req_i) & ~w_full;
   assign s_gnt_o = m_gnt_i & m_req_o & w_s_win;
   assign v_gnt_o = m_gnt_i & m_req_o & w_v_win;
   assign w_push  = m_req_o & m_gnt_i;
   assign w_pop   = m_rvalid_i & ~w_empty;

   always_comb begin
      w_s_be = '0;
      for (int k = 0; k < int'(NumLanes); k++) begin
         if (w_s_lane == LaneW'(k)) w_s_be[4*k +: 4] = s_be_i;
      end
   end

   assign m_addr_o  = w_v_win ? v_addr_i  : s_addr_i;
   assign m_we_o    = w_v_win ? v_we_i    : s_we_i;
   assign m_be_o    = w_v_win ? v_be_i    : w_s_be;
   assign m_wdata_o = w_v_win ? v_wdata_i : {NumLanes{s_wdata_i}};

   assign w_new_ent = w_v_win ? {1'b1, v_we_i, {LaneW{1'b0}}} : {1'b0, s_we_i, w_s_lane};

   // Response routing from the FIFO head
   assign w_head      = r_fifo[r_rptr];
   assign w_head_src  = w_head[EntW-1];
   assign w_head_we   = w_head[EntW-2];
   assign w_head_lane = w_head[LaneW-1:0];

   assign s_rvalid_o = w_pop & ~w_head_src;
   assign v_rvalid_o = w_pop & w_head_src & ~w_head_we;
   assign s_err_o    = w_pop & m_err_i & ~w_head_src;
   assign v_err_o    = w_pop & m_err_i & w_head_src;
   assign v_rdata_o  = m_rdata_i;

   always_comb begin
      s_rdata_o = '0;
      for (int k = 0; k < int'(NumLanes); k++) begin
         if (w_head_lane == LaneW'(k)) s_rdata_o = m_rdata_i[32*k +: 32];
      end
   end

   assign os_cnt_o    = r_cnt;
   assign proto_err_o = r_proto;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_starve <= '0;
         r_cnt    <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_proto  <= 1'b0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) r_fifo[i] <= '0;
      end else begin
         if (s_req_i && !s_gnt_o) begin
            if (r_starve != 8'(STARVE_LIMIT)) r_starve <= r_starve + 8'd1;
         end else begin
            r_starve <= '0;
         end

         if (w_push) begin
            r_fifo[r_wptr] <= w_new_ent;
            r_wptr         <= ptr_inc(r_wptr);
         end
         if (w_pop) r_rptr <= ptr_inc(r_rptr);

         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - 1'b1;
         end

         // A response with nothing in flight is a protocol violation; it is flagged, not popped.
         if (m_rvalid_i && w_empty) r_proto <= 1'b1;
      end
   end

endmodule
